wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the five-stage MIPS pipeline. It consumes the MEM/WB pipeline register outputs (wb_* signals) and the synchronous data-SRAM read data, and selects the final register-file write value. It owns the architectural HI/LO registers and a load-data hold buffer that keeps SRAM read data valid across stalls. It commits exactly one register-file write and one debug trace record per instruction.

## Interface
- No parameters.
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- stall  in  1  MEM/WB register holding this cycle; WB instruction does not retire
- refresh  in  1  pipeline flush; WB contents are discarded
- wb_pc, wb_inst, wb_res  in  32 each  pc, instruction word, ALU result (load byte address for loads)
- wb_load, wb_al, wb_regwen, wb_eret, wb_cp0ren  in  1 each  instruction class flags
- wb_wreg  in  5  destination GPR
- wb_cp0rdata, wb_hilordata  in  32 each  CP0 / HI-LO read values
- wb_hiloren, wb_hilowen  in  2 each  bit1 = HI, bit0 = LO
- wb_hilo_wdata  in  64  HI/LO write data {hi, lo}
- data_sram_rdata  in  32  SRAM read data, valid only in the first WB cycle of a load
- rf_wen  out  1; rf_waddr  out  5; rf_wdata  out  32  GPR write port
- hi_o, lo_o  out  32 each  architectural HI/LO
- wb_fwd_data  out  32  selected result, unconditioned, for bypass
- debug_wb_pc  out  32; debug_wb_rf_wen  out  4; debug_wb_rf_wnum  out  5; debug_wb_rf_wdata  out  32

## Operation
- Result select, in priority order: wb_cp0ren -> wb_cp0rdata; wb_hiloren != 0 -> wb_hilordata; wb_load -> aligned load data; wb_al -> wb_pc + 8; else wb_res.
- Load data source: hold_valid ? rdata_hold : data_sram_rdata.
- Load type decodes from wb_inst[31:26]: 100000 LB, 100100 LBU, 100001 LH, 100101 LHU, 100011 LW. Any other opcode with wb_load set is treated as LW.
- Byte offset wb_res[1:0] selects the byte (LB/LBU) or halfword (LH/LHU, offset[1]). LB/LH sign-extend; LBU/LHU zero-extend. LW ignores the offset.
- Hold buffer:
  - When stall=1 and hold_valid=0, capture data_sram_rdata into rdata_hold and set hold_valid.
  - When stall=0, clear hold_valid.
  - refresh or reset clears hold_valid and zeroes rdata_hold.
- Commit condition: commit = wb_regwen & (wb_wreg != 0) & ~stall & ~wb_eret.
  - rf_wen = commit; rf_waddr = wb_wreg; rf_wdata = selected result.
- HI/LO write on a clock edge with ~stall & ~refresh:
  - wb_hilowen[1] -> hi <= wb_hilo_wdata[63:32]
  - wb_hilowen[0] -> lo <= wb_hilo_wdata[31:0]
  - Both bits set write both in the same cycle.
- Debug trace:
  - debug_wb_pc = wb_pc
  - debug_wb_rf_wen = {4{commit}}
  - debug_wb_rf_wnum = wb_wreg
  - debug_wb_rf_wdata = rf_wdata

## Timing
- GPR write and debug outputs are combinational from current WB inputs. The register file samples them on the next edge, giving one commit per instruction because commit is gated by ~stall.
- Reset (resetn=0 at an edge) sets hi, lo, rdata_hold = 0 and hold_valid = 0. With zeroed WB inputs, every output evaluates to 0.
- Stall for N cycles on a load:
  - SRAM data is captured at the first stalled edge.
  - The held value is used for every remaining stalled cycle and the final commit cycle.
- Stall and refresh together: refresh wins. The hold buffer clears and HI/LO are not written.
- Reset mid-stall discards held data. A pending HI/LO write is dropped.
- wb_pc + 8 wraps modulo 2^32.

## Structure
- Shared package cpu_defs holds the opcode constants (OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW) and the hilo bit indices.
- One sub-module, load_align: purely combinational (rdata, offset, opcode) -> 32-bit extended value.
- HI/LO registers, hold buffer and select logic live in wb_stage.

## Test plan
- LB at address offset 3, rdata 0x80FF_1234, no stall -> rf_wdata 0xFFFF_FF80, rf_wen 1 for one cycle.
- LHU at offset 2, rdata 0x8001_0000, stall 3 cycles while the SRAM bus changes to 0xDEADBEEF -> one commit of 0x0000_8001 on the first unstalled cycle, debug_wb_rf_wen 0xF.
- MULT result wb_hilowen=2'b11, wb_hilo_wdata=0x1_0000_0002 -> next cycle hi_o=1, lo_o=2. The same write with stall=1 leaves HI/LO unchanged.
- JAL with wb_al=1, wb_pc=0xBFC0_0100, wb_wreg=31 -> rf_wdata 0xBFC0_0108. With wb_wreg=0 -> rf_wen 0.
- MFC0 with wb_cp0ren=1 and wb_load=1 both set -> CP0 data wins. Eret with wb_regwen=1 -> no commit.
- Reset asserted during a stalled load -> hold_valid 0, hi/lo 0, and after release the next load uses live SRAM data.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: load opcodes and HI/LO write-enable bit positions.
package cpu_defs;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LW  = 6'b100011;

   localparam int HILO_HI = 1;
   localparam int HILO_LO = 0;

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword from a 32-bit load word and extends it.
module load_align
   import cpu_defs::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [5:0]  opcode,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the byte and halfword lanes addressed by the offset.
   always_comb begin
      byte_sel = rdata[7:0];
      case (offset)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         2'd3:    byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      if (offset[1]) begin
         half_sel = rdata[31:16];
      end else begin
         half_sel = rdata[15:0];
      end
   end

   // Unknown load opcodes fall back to a full-word load.
   always_comb begin
      data = rdata;
      case (opcode)
         OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  data = {24'd0, byte_sel};
         OP_LH:   data = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  data = {16'd0, half_sel};
         OP_LW:   data = rdata;
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: result select, load-data hold across stalls, HI/LO registers
// and the GPR write / debug trace port.
module wb_stage
   import cpu_defs::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        stall,
   input  logic        refresh,
   input  logic [31:0] wb_pc,
   input  logic [31:0] wb_inst,
   input  logic [31:0] wb_res,
   input  logic        wb_load,
   input  logic        wb_al,
   input  logic        wb_regwen,
   input  logic        wb_eret,
   input  logic        wb_cp0ren,
   input  logic [4:0]  wb_wreg,
   input  logic [31:0] wb_cp0rdata,
   input  logic [31:0] wb_hilordata,
   input  logic [1:0]  wb_hiloren,
   input  logic [1:0]  wb_hilowen,
   input  logic [63:0] wb_hilo_wdata,
   input  logic [31:0] data_sram_rdata,
   output logic        rf_wen,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic [31:0] wb_fwd_data,
   output logic [31:0] debug_wb_pc,
   output logic [3:0]  debug_wb_rf_wen,
   output logic [4:0]  debug_wb_rf_wnum,
   output logic [31:0] debug_wb_rf_wdata
);

   logic        hold_valid;
   logic [31:0] rdata_hold;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] load_src;
   logic [31:0] load_data;
   logic [31:0] result;
   logic        commit;

   // SRAM data is only valid in the first WB cycle, so freeze it on the first stalled edge.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         hold_valid <= 1'b0;
         rdata_hold <= 32'd0;
      end else if (refresh) begin
         hold_valid <= 1'b0;
         rdata_hold <= 32'd0;
      end else if (stall) begin
         if (!hold_valid) begin
            hold_valid <= 1'b1;
            rdata_hold <= data_sram_rdata;
         end
      end else begin
         hold_valid <= 1'b0;
      end
   end

   // Architectural HI/LO; written only when the instruction actually retires.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         hi <= 32'd0;
         lo <= 32'd0;
      end else if (!stall && !refresh) begin
         if (wb_hilowen[HILO_HI]) hi <= wb_hilo_wdata[63:32];
         if (wb_hilowen[HILO_LO]) lo <= wb_hilo_wdata[31:0];
      end
   end

   assign load_src = hold_valid ? rdata_hold : data_sram_rdata;

   load_align u_load_align (
      .rdata  (load_src),
      .offset (wb_res[1:0]),
      .opcode (wb_inst[31:26]),
      .data   (load_data)
   );

   // Result select in priority order.
   always_comb begin
      result = wb_res;
      if (wb_cp0ren) begin
         result = wb_cp0rdata;
      end else if (wb_hiloren != 2'b00) begin
         result = wb_hilordata;
      end else if (wb_load) begin
         result = load_data;
      end else if (wb_al) begin
         result = wb_pc + 32'd8;
      end else begin
         result = wb_res;
      end
   end

   assign commit = wb_regwen & (wb_wreg != 5'd0) & ~stall & ~wb_eret;

   assign rf_wen            = commit;
   assign rf_waddr          = wb_wreg;
   assign rf_wdata          = result;
   assign wb_fwd_data       = result;
   assign hi_o              = hi;
   assign lo_o              = lo;
   assign debug_wb_pc       = wb_pc;
   assign debug_wb_rf_wen   = {4{commit}};
   assign debug_wb_rf_wnum  = wb_wreg;
   assign debug_wb_rf_wdata = result;

endmodule

// File: tb/tb_wb_stage.sv
// Directed plus randomized checks of wb_stage against a behavioural model.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        resetn, stall, refresh;
   logic [31:0] wb_pc, wb_inst, wb_res;
   logic        wb_load, wb_al, wb_regwen, wb_eret, wb_cp0ren;
   logic [4:0]  wb_wreg;
   logic [31:0] wb_cp0rdata, wb_hilordata;
   logic [1:0]  wb_hiloren, wb_hilowen;
   logic [63:0] wb_hilo_wdata;
   logic [31:0] data_sram_rdata;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata, hi_o, lo_o, wb_fwd_data, debug_wb_pc, debug_wb_rf_wdata;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;

   int passed = 0;
   int total  = 0;

   // model state
   logic [31:0] m_hi, m_lo, m_hold;
   logic        m_hv;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk(clk), .resetn(resetn), .stall(stall), .refresh(refresh),
      .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_res(wb_res),
      .wb_load(wb_load), .wb_al(wb_al), .wb_regwen(wb_regwen), .wb_eret(wb_eret),
      .wb_cp0ren(wb_cp0ren), .wb_wreg(wb_wreg),
      .wb_cp0rdata(wb_cp0rdata), .wb_hilordata(wb_hilordata),
      .wb_hiloren(wb_hiloren), .wb_hilowen(wb_hilowen), .wb_hilo_wdata(wb_hilo_wdata),
      .data_sram_rdata(data_sram_rdata),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .hi_o(hi_o), .lo_o(lo_o), .wb_fwd_data(wb_fwd_data),
      .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
      .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic clear_inputs();
      stall = 1'b0; refresh = 1'b0;
      wb_pc = 32'd0; wb_inst = 32'd0; wb_res = 32'd0;
      wb_load = 1'b0; wb_al = 1'b0; wb_regwen = 1'b0; wb_eret = 1'b0; wb_cp0ren = 1'b0;
      wb_wreg = 5'd0; wb_cp0rdata = 32'd0; wb_hilordata = 32'd0;
      wb_hiloren = 2'b00; wb_hilowen = 2'b00; wb_hilo_wdata = 64'd0;
      data_sram_rdata = 32'd0;
   endtask

   // Expected outputs for the current inputs and model state.
   task automatic check_now();
      logic [31:0] src, w, h, ld, sel;
      logic        com;
      src = m_hv ? m_hold : data_sram_rdata;
      w   = src >> (8 * wb_res[1:0]);
      h   = src >> (16 * wb_res[1]);
      case (wb_inst[31:26])
         6'h20:   ld = {{24{w[7]}}, w[7:0]};
         6'h24:   ld = w & 32'h0000_00FF;
         6'h21:   ld = {{16{h[15]}}, h[15:0]};
         6'h25:   ld = h & 32'h0000_FFFF;
         default: ld = src;
      endcase
      if (wb_cp0ren)               sel = wb_cp0rdata;
      else if (wb_hiloren != 2'b00) sel = wb_hilordata;
      else if (wb_load)            sel = ld;
      else if (wb_al)              sel = wb_pc + 32'd8;
      else                         sel = wb_res;
      com = wb_regwen && (wb_wreg != 5'd0) && !stall && !wb_eret;
      chk("rf_wen", rf_wen, com);
      chk("rf_waddr", rf_waddr, wb_wreg);
      chk("rf_wdata", rf_wdata, sel);
      chk("fwd", wb_fwd_data, sel);
      chk("hi", hi_o, m_hi);
      chk("lo", lo_o, m_lo);
      chk("dbg_pc", debug_wb_pc, wb_pc);
      chk("dbg_wen", debug_wb_rf_wen, com ? 4'hF : 4'h0);
      chk("dbg_wnum", debug_wb_rf_wnum, wb_wreg);
      chk("dbg_wdata", debug_wb_rf_wdata, sel);
   endtask

   // Advance one clock and apply the clock-edge rules to the model.
   task automatic tick();
      @(posedge clk);
      if (!resetn) begin
         m_hi = 32'd0; m_lo = 32'd0; m_hold = 32'd0; m_hv = 1'b0;
      end else begin
         if (!stall && !refresh) begin
            if (wb_hilowen[1]) m_hi = wb_hilo_wdata[63:32];
            if (wb_hilowen[0]) m_lo = wb_hilo_wdata[31:0];
         end
         if (refresh) begin
            m_hv = 1'b0; m_hold = 32'd0;
         end else if (stall) begin
            if (!m_hv) begin m_hold = data_sram_rdata; m_hv = 1'b1; end
         end else begin
            m_hv = 1'b0;
         end
      end
      #1;
   endtask

   task automatic step();
      @(negedge clk);
      check_now();
      tick();
   endtask

   task automatic randomize_inputs();
      logic [5:0] ops [6];
      ops[0] = 6'h20; ops[1] = 6'h24; ops[2] = 6'h21; ops[3] = 6'h25; ops[4] = 6'h23; ops[5] = 6'h0F;
      resetn    = ($urandom_range(0, 39) != 0);
      stall     = ($urandom_range(0, 9) < 4);
      refresh   = ($urandom_range(0, 9) == 0);
      wb_pc     = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
      wb_inst   = {ops[$urandom_range(0, 5)], 26'($urandom)};
      wb_res    = $urandom;
      wb_load   = $urandom_range(0, 1) == 1;
      wb_al     = $urandom_range(0, 3) == 0;
      wb_regwen = $urandom_range(0, 3) != 0;
      wb_eret   = $urandom_range(0, 9) == 0;
      wb_cp0ren = $urandom_range(0, 7) == 0;
      wb_wreg   = 5'($urandom);
      wb_cp0rdata  = $urandom;
      wb_hilordata = $urandom;
      wb_hiloren   = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
      wb_hilowen   = 2'($urandom);
      wb_hilo_wdata = {$urandom, $urandom};
      data_sram_rdata = $urandom;
   endtask

   initial begin
      m_hi = 32'd0; m_lo = 32'd0; m_hold = 32'd0; m_hv = 1'b0;
      clear_inputs();
      resetn = 1'b0;
      tick(); tick();
      @(negedge clk);
      chk("reset_rf_wdata", rf_wdata, 32'd0);
      chk("reset_hi", hi_o, 32'd0);
      chk("reset_lo", lo_o, 32'd0);
      chk("reset_dbg_wen", debug_wb_rf_wen, 4'h0);
      check_now();
      tick();
      resetn = 1'b1;

      // LB offset 3, sign-extended
      wb_load = 1'b1; wb_regwen = 1'b1; wb_wreg = 5'd4;
      wb_inst = {6'b100000, 26'd0}; wb_res = 32'h1000_0003; data_sram_rdata = 32'h80FF_1234;
      @(negedge clk);
      chk("lb_data", rf_wdata, 32'hFFFF_FF80);
      chk("lb_wen", rf_wen, 1'b1);
      check_now(); tick();

      // LHU offset 2 held across 3 stalled cycles while the bus changes
      wb_inst = {6'b100101, 26'd0}; wb_res = 32'h1000_0002; data_sram_rdata = 32'h8001_0000;
      stall = 1'b1; wb_wreg = 5'd6;
      @(negedge clk); chk("lhu_stall_wen", rf_wen, 1'b0); check_now(); tick();
      data_sram_rdata = 32'hDEAD_BEEF;
      step(); step();
      stall = 1'b0;
      @(negedge clk);
      chk("lhu_data", rf_wdata, 32'h0000_8001);
      chk("lhu_dbg_wen", debug_wb_rf_wen, 4'hF);
      check_now(); tick();
      clear_inputs();

      // MULT writes both HI and LO; stalled write is dropped
      wb_hilowen = 2'b11; wb_hilo_wdata = 64'h1_0000_0002;
      step();
      wb_hilo_wdata = 64'h5_0000_0006; stall = 1'b1;
      @(negedge clk);
      chk("mult_hi", hi_o, 32'd1);
      chk("mult_lo", lo_o, 32'd2);
      check_now(); tick();
      @(negedge clk);
      chk("mult_stall_hi", hi_o, 32'd1);
      chk("mult_stall_lo", lo_o, 32'd2);
      check_now(); tick();
      clear_inputs();

      // JAL link value, then $0 destination suppresses the write; pc+8 wraps
      wb_al = 1'b1; wb_regwen = 1'b1; wb_pc = 32'hBFC0_0100; wb_wreg = 5'd31;
      @(negedge clk);
      chk("jal_data", rf_wdata, 32'hBFC0_0108);
      chk("jal_wen", rf_wen, 1'b1);
      check_now(); tick();
      wb_wreg = 5'd0;
      @(negedge clk); chk("jal_r0_wen", rf_wen, 1'b0); check_now(); tick();
      wb_wreg = 5'd31; wb_pc = 32'hFFFF_FFFC;
      @(negedge clk); chk("jal_wrap", rf_wdata, 32'h0000_0004); check_now(); tick();
      clear_inputs();

      // MFC0 beats load; eret suppresses commit
      wb_cp0ren = 1'b1; wb_load = 1'b1; wb_regwen = 1'b1; wb_wreg = 5'd9;
      wb_cp0rdata = 32'h1234_5678; data_sram_rdata = 32'hCAFE_F00D; wb_inst = {6'b100011, 26'd0};
      @(negedge clk); chk("mfc0_data", rf_wdata, 32'h1234_5678); check_now(); tick();
      clear_inputs();
      wb_eret = 1'b1; wb_regwen = 1'b1; wb_wreg = 5'd3;
      @(negedge clk); chk("eret_wen", rf_wen, 1'b0); check_now(); tick();
      clear_inputs();

      // Reset during a stalled load discards held data and HI/LO
      wb_load = 1'b1; wb_regwen = 1'b1; wb_wreg = 5'd7; wb_inst = {6'b100011, 26'd0};
      data_sram_rdata = 32'hAAAA_5555; stall = 1'b1;
      step();
      resetn = 1'b0; wb_hilowen = 2'b11; wb_hilo_wdata = 64'h7_0000_0008;
      step();
      resetn = 1'b1; stall = 1'b0; wb_hilowen = 2'b00; data_sram_rdata = 32'h1357_2468;
      @(negedge clk);
      chk("rst_hi", hi_o, 32'd0);
      chk("rst_lo", lo_o, 32'd0);
      chk("rst_live_load", rf_wdata, 32'h1357_2468);
      check_now(); tick();

      for (int i = 0; i < 600; i++) begin
         randomize_inputs();
         step();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
